// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_ctrl
// Purpose  : Scan-test sequencer for an attached CHAIN_LEN-bit mux-D scan
//            chain. Each accepted start runs load -> capture -> unload ->
//            compare, reports pass/fail and keeps a saturating fail count.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start_i          - run request (sampled in IDLE only)
//            pattern_i        - stimulus, latched on start acceptance
//            expected_i       - expected response, latched on acceptance
//            scan_en_o        - chain shift enable (1 = shift)
//            scan_in_o        - serial data into chain bit 0
//            scan_out_i       - serial data from chain bit CHAIN_LEN-1
//            busy_o           - high in LOAD, CAPTURE, UNLOAD
//            done_o           - one-cycle end-of-run pulse
//            pass_o           - result of last completed run
//            captured_o       - response unloaded in last run
//            fail_count_o     - failed runs since reset, saturates at 255
// Revision : 1.0 - initial release
// ============================================================================
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] pattern_i,
  input  logic [CHAIN_LEN-1:0] expected_i,
  output logic                 scan_en_o,
  output logic                 scan_in_o,
  input  logic                 scan_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CHAIN_LEN-1:0] captured_o,
  output logic [7:0]           fail_count_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CHAIN_LEN-1:0] pat_q;      // remaining stimulus bits, next bit in MSB
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] shift_q;    // response assembled so far, first sample moves toward MSB
  logic                 scan_en_q;
  logic                 scan_in_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [CHAIN_LEN-1:0] captured_q;
  logic [7:0]           fail_count_q;

  // Next value of the assembled response, including the sample taken on the
  // current edge. On the final unload edge this is the complete response.
  logic [CHAIN_LEN-1:0] captured_d;
  logic [7:0]           fail_count_d;

  assign captured_d   = {shift_q[CHAIN_LEN-2:0], scan_out_i};
  assign fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      exp_q        <= '0;
      shift_q      <= '0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      captured_q   <= '0;
      fail_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // First stimulus bit (MSB) is presented in load cycle 0, so it is
            // registered here; the rest stay queued in pat_q.
            pat_q     <= {pattern_i[CHAIN_LEN-2:0], 1'b0};
            exp_q     <= expected_i;
            cnt_q     <= '0;
            scan_en_q <= 1'b1;
            scan_in_q <= pattern_i[CHAIN_LEN-1];
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (cnt_q == c_LAST) begin
            cnt_q     <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            state_q   <= S_CAPTURE;
          end else begin
            cnt_q     <= cnt_q + c_ONE;
            scan_in_q <= pat_q[CHAIN_LEN-1];
            pat_q     <= {pat_q[CHAIN_LEN-2:0], 1'b0};
          end
        end

        S_CAPTURE: begin
          cnt_q     <= '0;
          scan_en_q <= 1'b1;
          scan_in_q <= 1'b0;
          state_q   <= S_UNLOAD;
        end

        S_UNLOAD: begin
          shift_q <= captured_d;
          if (cnt_q == c_LAST) begin
            cnt_q      <= '0;
            scan_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            captured_q <= captured_d;
            pass_q     <= (captured_d == exp_q);
            if (captured_d != exp_q) begin
              fail_count_q <= fail_count_d;
            end
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + c_ONE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          scan_en_q <= 1'b0;
          scan_in_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign scan_en_o    = scan_en_q;
  assign scan_in_o    = scan_in_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign captured_o   = captured_q;
  assign fail_count_o = fail_count_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_test_ctrl
// Purpose  : Self-checking bench for scan_test_ctrl with an attached 4-bit
//            scan chain whose functional input is d = ~q. Expected run
//            results are queued at start acceptance and compared on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_test_ctrl;

  localparam int CHAIN_LEN = 4;
  localparam int CNT_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_i = 1'b0;
  logic [CHAIN_LEN-1:0] pattern_i = '0;
  logic [CHAIN_LEN-1:0] expected_i = '0;
  logic                 scan_en_o;
  logic                 scan_in_o;
  logic                 scan_out_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic [CHAIN_LEN-1:0] captured_o;
  logic [7:0]           fail_count_o;

  scan_test_ctrl #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pattern_i    (pattern_i),
    .expected_i   (expected_i),
    .scan_en_o    (scan_en_o),
    .scan_in_o    (scan_in_o),
    .scan_out_i   (scan_out_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .captured_o   (captured_o),
    .fail_count_o (fail_count_o)
  );

  always #5 clk = ~clk;

  // Attached mux-D scan chain: shift when scan_en, else capture d = ~q.
  logic [CHAIN_LEN-1:0] chain_q = '0;
  always @(posedge clk) begin
    if (scan_en_o) chain_q <= {chain_q[CHAIN_LEN-2:0], scan_in_o};
    else           chain_q <= ~chain_q;
  end
  assign scan_out_i = chain_q[CHAIN_LEN-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int                   acc;
    logic [CHAIN_LEN-1:0] cap;
    logic                 pass;
    logic [7:0]           fc;
  } exp_t;

  exp_t sb[$];
  int   model_fc = 0;

  // Predict the result of a run accepted at edge 'acc'.
  task automatic push_run(input int acc, input logic [CHAIN_LEN-1:0] pat,
                          input logic [CHAIN_LEN-1:0] exp);
    exp_t e;
    e.acc  = acc;
    e.cap  = ~pat;
    e.pass = (e.cap == exp);
    if (!e.pass && model_fc < 255) model_fc++;
    e.fc   = 8'(model_fc);
    sb.push_back(e);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.acc + 2*CHAIN_LEN + 1));
        check("captured",   32'(captured_o), 32'(e.cap));
        check("pass",       32'(pass_o), 32'(e.pass));
        check("fail_count", 32'(fail_count_o), 32'(e.fc));
      end
    end
  end

  // Wait (bounded) for done; returns at the negedge of the done cycle.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4*CHAIN_LEN; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  // One run. seq_chk checks the per-cycle scan sequence; inject pulses start
  // with a different pattern during LOAD and UNLOAD.
  task automatic run(input logic [CHAIN_LEN-1:0] pat, input logic [CHAIN_LEN-1:0] exp,
                     input bit seq_chk, input bit inject);
    bit ok;
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    pattern_i  = pat;
    expected_i = exp;
    push_run(cyc + 1, pat, exp);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int k = 0; k < 2*CHAIN_LEN + 1; k++) begin
      @(negedge clk);
      if (seq_chk) begin
        if (k < CHAIN_LEN) begin
          check("load_scan_en", 32'(scan_en_o), 32'd1);
          check("load_scan_in", 32'(scan_in_o), 32'(pat[CHAIN_LEN-1-k]));
        end else if (k == CHAIN_LEN) begin
          check("capt_scan_en", 32'(scan_en_o), 32'd0);
          check("capt_scan_in", 32'(scan_in_o), 32'd0);
        end else begin
          check("unld_scan_en", 32'(scan_en_o), 32'd1);
          check("unld_scan_in", 32'(scan_in_o), 32'd0);
        end
        check("run_busy", 32'(busy_o), 32'd1);
      end
      if (inject) begin
        if (k == 1 || k == CHAIN_LEN + 2) begin
          start_i    = 1'b1;
          pattern_i  = ~pat ^ 4'(k);
          expected_i = 4'(k);
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    wait_done(ok);
  endtask

  initial begin
    bit ok;

    // 1. Reset and idle state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scan_en",    32'(scan_en_o), 32'd0);
    check("rst_busy",       32'(busy_o), 32'd0);
    check("rst_done",       32'(done_o), 32'd0);
    check("rst_pass",       32'(pass_o), 32'd0);
    check("rst_captured",   32'(captured_o), 32'd0);
    check("rst_fail_count", 32'(fail_count_o), 32'd0);

    // 2. Passing run with full sequence check.
    run(4'b1010, 4'b0101, 1'b1, 1'b0);

    // 3. Failing run, twice.
    run(4'b1100, 4'b1100, 1'b0, 1'b0);
    run(4'b1100, 4'b1100, 1'b0, 1'b0);

    // 4. start while busy: ignored, result follows the latched pattern.
    run(4'b1001, 4'b0110, 1'b1, 1'b1);
    repeat (2*CHAIN_LEN + 4) @(negedge clk);
    check("inject_idle_busy", 32'(busy_o), 32'd0);

    // 5. Reset in the 2nd UNLOAD cycle; no done, counters cleared.
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    pattern_i  = 4'b0101;
    expected_i = 4'b0000;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (CHAIN_LEN + 3) @(negedge clk);   // now in cycle acc+CHAIN_LEN+2
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scan_en",    32'(scan_en_o), 32'd0);
    check("midrst_busy",       32'(busy_o), 32'd0);
    check("midrst_done",       32'(done_o), 32'd0);
    check("midrst_fail_count", 32'(fail_count_o), 32'd0);
    rst = 1'b0;
    model_fc = 0;
    repeat (2*CHAIN_LEN + 4) @(negedge clk);
    check("midrst_no_run", 32'(sb.size()), 32'd0);
    run(4'b0110, 4'b1001, 1'b0, 1'b0);

    // 6. Back-to-back failing runs with start held high; saturation at 255.
    @(posedge clk);
    #1;
    pattern_i  = 4'b0011;
    expected_i = 4'b0011;
    start_i    = 1'b1;
    push_run(cyc + 1, 4'b0011, 4'b0011);
    for (int i = 0; i < 260; i++) begin
      wait_done(ok);
      if (!ok) break;
      if (i < 259) push_run(cyc + 2, 4'b0011, 4'b0011);
      else         start_i = 1'b0;
    end
    start_i = 1'b0;
    repeat (2*CHAIN_LEN + 4) @(negedge clk);
    check("sat_fail_count", 32'(fail_count_o), 32'd255);
    check("sb_drained",     32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- Scan-test sequencer that sits directly upstream of a CHAIN_LEN-bit mux-D scan chain.
- It drives the chain's scan_en and scan_in, and consumes the chain's scan_out.
- For each start request it runs one full test: load a stimulus pattern, pulse one functional capture, unload the response, then compare the response against an expected vector.
- It reports pass/fail per run and keeps a running saturating failure count.

Parameters:
- CHAIN_LEN, 4, number of flops in the attached scan chain (>=2).
- CNT_W, 3, width of the internal shift counter; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  single clock for the controller and the scan chain.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  run request, sampled only in IDLE.
- pattern  input  CHAIN_LEN  stimulus to load; latched on start acceptance.
- expected  input  CHAIN_LEN  expected captured response; latched on start acceptance.
- scan_en  output  1  chain shift enable: 1 = shift, 0 = functional capture/hold.
- scan_in  output  1  serial data into chain bit 0.
- scan_out  input  1  serial data from the chain's last bit, q[CHAIN_LEN-1].
- busy  output  1  high in LOAD, CAPTURE and UNLOAD.
- done  output  1  one-cycle pulse; marks the end of a run.
- pass  output  1  result of the last completed run; valid from the done cycle onward.
- captured  output  CHAIN_LEN  response unloaded in the last run.
- fail_count  output  8  number of failed runs since reset; saturates at 255.

Behaviour:
- Reset values (on the first rising clk with rst=1):
  - state=IDLE.
  - scan_en=0, scan_in=0, busy=0, done=0, pass=0.
  - captured=0, fail_count=0, counter=0.
- Reset mid-run aborts immediately. The chain contents are then undefined, and no done pulse is issued.
- All outputs are driven from registers or decoded from the state register. There is no combinational path from start or scan_out to any output.
- IDLE:
  - scan_en=0.
  - When start=1 at an edge: latch pattern and expected, clear counter, go to LOAD.
- LOAD, exactly CHAIN_LEN cycles:
  - scan_en=1.
  - scan_in = pattern_latched[CHAIN_LEN-1-k] in load cycle k (k=0..CHAIN_LEN-1), i.e. MSB first.
  - After the last shift edge, chain q equals pattern. Then go to CAPTURE.
- CAPTURE, exactly 1 cycle:
  - scan_en=0, scan_in=0.
  - The chain captures its functional d inputs on this edge. Then go to UNLOAD.
- UNLOAD, exactly CHAIN_LEN cycles:
  - scan_en=1, scan_in=0.
  - At the edge ending unload cycle k, sample scan_out into captured_shift[CHAIN_LEN-1-k]. The first sample is the pre-shift q[CHAIN_LEN-1].
  - After the last cycle, go to DONE.
- DONE, exactly 1 cycle:
  - busy=0, scan_en=0, done=1.
  - captured <= assembled response.
  - pass <= (assembled response == expected_latched).
  - On mismatch, fail_count increments, saturating at 255.
  - Then go to IDLE.
- Timing: if start is accepted at edge E, done is high in the cycle beginning at edge E + 2*CHAIN_LEN + 1.
- start is ignored in every state except IDLE; there is no queuing. start held high continuously yields back-to-back runs with one IDLE cycle between them.
- pass and captured hold their values until the next DONE, or until reset.
- pattern and expected may change freely after acceptance without affecting the current run.

Test Plan:
1. Reset, then check the idle state.
   - Stimulus: assert rst for 2 cycles, then idle 3 cycles.
   - Required: scan_en=0, busy=0, done=0, pass=0, captured=0, fail_count=0.
2. Passing run.
   - Setup: CHAIN_LEN=4; attached 4-bit chain with d = ~q. Stimulus: pattern=4'b1010, expected=4'b0101, 1-cycle start.
   - Required: scan_in sequence 1,0,1,0 with scan_en=1 for 4 cycles; then scan_en=0 for 1 cycle; then 4 unload cycles.
   - Required: done pulses exactly 9 cycles after start acceptance, with captured=4'b0101, pass=1, fail_count=0.
3. Failing run.
   - Stimulus: pattern=4'b1100, expected=4'b1100 (true response is 4'b0011).
   - Required: captured=4'b0011, pass=0, fail_count=1.
   - A second identical run gives fail_count=2.
4. start while busy.
   - Stimulus: pulse start during LOAD and again during UNLOAD, with a different pattern each time.
   - Required: exactly one done; result matches the originally latched pattern; the run length is unchanged.
5. Reset mid-operation.
   - Stimulus: assert rst in the 2nd UNLOAD cycle.
   - Required: next cycle scan_en=0, busy=0; no done pulse; fail_count=0; a subsequent run with pattern=4'b0110 yields captured=4'b1001, pass=1 when expected=4'b1001.
6. Saturation and back-to-back.
   - Stimulus: hold start=1 with a mismatching expected for 260 runs.
   - Required: runs are separated by exactly one IDLE cycle; fail_count stops at 255 and never wraps.
